// File: rtl/cluster_out_drain.sv
// Generic synchronous FIFO used as the skid buffer behind the cluster read port.
// Latency: push visible at the head one cycle later; head is combinational from storage.
// Backpressure: none internally; caller must never push when full (pop proceeds when non-empty).
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   input  logic          pop_rdy,
   output logic [W-1:0]  pop_dat,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;

   assign pop     = pop_rdy && (count != '0);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop)      rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         count <= count + CW'(push_vld) - CW'(pop);
      end
   end
endmodule

// Drains one output buffer slot from every compute unit after chunk end, as a tagged stream.
// Latency: start -> wait chunk end -> UNIT_NUM issues -> RD_LAT -> FIFO -> stream; done one cycle after last word.
// Backpressure: reads issue only against free credits (FIFO space minus in-flight reads); a pop frees a credit same cycle.
module cluster_out_drain #(
   parameter int UNIT_NUM   = 4,
   parameter int BUF_NUM    = 4,
   parameter int DAT_W      = 32,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4,
   localparam int UW        = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1,
   localparam int BW        = (BUF_NUM > 1) ? $clog2(BUF_NUM) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             chunk_end_i,
   input  logic             drain_start_i,
   input  logic [BW-1:0]    drain_buf_i,
   output logic [BW-1:0]    out_buf_sel_o,
   output logic [UW-1:0]    unit_sel_o,
   input  logic [DAT_W-1:0] out_buf_dat_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [DAT_W-1:0] m_data_o,
   output logic [UW-1:0]    m_unit_o,
   output logic             m_last_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [UW-1:0] unit;
      logic          last;
   } tag_t;

   typedef struct packed {
      tag_t             tag;
      logic [DAT_W-1:0] dat;
   } ent_t;

   typedef enum logic [1:0] {IDLE, WAIT_END, ISSUE, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [UW-1:0] cnt_q;
   logic [UW-1:0] usel_q;
   logic [BW-1:0] sel_q;

   logic [CW-1:0] fifo_count;
   logic [CW-1:0] inflight;
   logic [CW-1:0] credits;
   logic          pop;
   logic          issue;
   logic          cap_vld;
   tag_t          iss_tag;
   tag_t          cap_tag;
   ent_t          push_ent;
   ent_t          head;

   assign m_valid_o = (fifo_count != '0);
   assign pop       = m_valid_o && m_ready_i;
   assign credits   = CW'(FIFO_DEPTH) - fifo_count - inflight;
   assign issue     = (state_q == ISSUE) && ((credits != '0) || pop);
   assign iss_tag   = '{unit: cnt_q, last: (cnt_q == UW'(UNIT_NUM - 1))};

   // Tag pipe mirrors the cluster read latency so each word lands with its unit index.
   generate
      if (RD_LAT == 0) begin : g_no_pipe
         assign cap_vld  = issue;
         assign cap_tag  = iss_tag;
         assign inflight = '0;
      end else begin : g_pipe
         logic [RD_LAT-1:0] pv;
         tag_t              pt [RD_LAT];

         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               pv <= '0;
               for (int j = 0; j < RD_LAT; j++) pt[j] <= '0;
            end else begin
               pv[0] <= issue;
               pt[0] <= iss_tag;
               for (int j = 1; j < RD_LAT; j++) begin
                  pv[j] <= pv[j-1];
                  pt[j] <= pt[j-1];
               end
            end
         end

         always_comb begin
            inflight = '0;
            for (int j = 0; j < RD_LAT; j++) inflight = inflight + CW'(pv[j]);
         end

         assign cap_vld = pv[RD_LAT-1];
         assign cap_tag = pt[RD_LAT-1];
      end
   endgenerate

   assign push_ent = '{tag: cap_tag, dat: out_buf_dat_i};

   fifo #(
      .W     ($bits(ent_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_skid (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_vld (cap_vld),
      .push_dat (push_ent),
      .pop_rdy  (m_ready_i),
      .pop_dat  (head),
      .count    (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      done_o  = 1'b0;
      case (state_q)
         IDLE:     if (drain_start_i) state_d = WAIT_END;
         WAIT_END: if (chunk_end_i) state_d = ISSUE;
         ISSUE:    if (issue && iss_tag.last) state_d = FLUSH;
         FLUSH: begin
            if ((inflight == '0) && !m_valid_o) begin
               done_o  = 1'b1;
               state_d = IDLE;
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         usel_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && drain_start_i) begin
            sel_q <= drain_buf_i;
            cnt_q <= '0;
         end
         if (issue) begin
            cnt_q  <= cnt_q + UW'(1);
            usel_q <= cnt_q;
         end else if (done_o) begin
            usel_q <= '0;
         end
      end
   end

   assign busy_o        = (state_q != IDLE) && !done_o;
   assign out_buf_sel_o = sel_q;
   assign unit_sel_o    = issue ? cnt_q : usel_q;
   // Head storage is undefined when empty; keep the stream outputs quiet instead.
   assign m_data_o      = m_valid_o ? head.dat : '0;
   assign m_unit_o      = m_valid_o ? head.tag.unit : '0;
   assign m_last_o      = m_valid_o && head.tag.last;
endmodule

// File: tb/tb_cluster_out_drain.sv
// Directed bench for cluster_out_drain: two instances (4 units/RD_LAT 1, 8 units/RD_LAT 2)
// each fed by a small cluster read model that returns a known word per (buffer, unit).
module tb_cluster_out_drain;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [1:0] s, input logic [2:0] u);
      return {4'hC, 2'b00, s, 8'(u) * 8'd17 + 8'd5};
   endfunction

   // instance a: 4 units, RD_LAT 1
   logic        a_start, a_chunk, a_ready;
   logic [1:0]  a_buf, a_sel, a_usel, a_unit;
   logic [15:0] a_dat, a_data;
   logic        a_vld, a_last, a_busy, a_done;

   cluster_out_drain #(.UNIT_NUM(4), .BUF_NUM(4), .DAT_W(16), .RD_LAT(1), .FIFO_DEPTH(4)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .chunk_end_i(a_chunk), .drain_start_i(a_start),
      .drain_buf_i(a_buf), .out_buf_sel_o(a_sel), .unit_sel_o(a_usel), .out_buf_dat_i(a_dat),
      .m_valid_o(a_vld), .m_ready_i(a_ready), .m_data_o(a_data), .m_unit_o(a_unit),
      .m_last_o(a_last), .busy_o(a_busy), .done_o(a_done));

   always @(posedge clk) a_dat <= mk(a_sel, {1'b0, a_usel});

   // instance b: 8 units, RD_LAT 2
   logic        b_start, b_chunk, b_ready;
   logic [1:0]  b_buf, b_sel;
   logic [2:0]  b_usel, b_unit;
   logic [15:0] b_d1, b_dat, b_data;
   logic        b_vld, b_last, b_busy, b_done;

   cluster_out_drain #(.UNIT_NUM(8), .BUF_NUM(4), .DAT_W(16), .RD_LAT(2), .FIFO_DEPTH(4)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .chunk_end_i(b_chunk), .drain_start_i(b_start),
      .drain_buf_i(b_buf), .out_buf_sel_o(b_sel), .unit_sel_o(b_usel), .out_buf_dat_i(b_dat),
      .m_valid_o(b_vld), .m_ready_i(b_ready), .m_data_o(b_data), .m_unit_o(b_unit),
      .m_last_o(b_last), .busy_o(b_busy), .done_o(b_done));

   always @(posedge clk) begin
      b_d1  <= mk(b_sel, b_usel);
      b_dat <= b_d1;
   end

   task automatic a_go(input logic [1:0] bs);
      @(negedge clk); a_buf = bs; a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
   endtask

   task automatic b_go(input logic [1:0] bs);
      @(negedge clk); b_buf = bs; b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
   endtask

   task automatic a_collect(input logic [1:0] bs, input int first);
      int n = first;
      int dones = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (a_vld) begin
            check("a_unit", 32'(a_unit), 32'(n));
            check("a_data", 32'(a_data), 32'(mk(bs, 3'(n))));
            check("a_last", 32'(a_last), 32'(n == 3));
            n++;
         end
         if (a_done) begin
            dones++;
            check("a_busy_at_done", 32'(a_busy), 32'(0));
            break;
         end
      end
      check("a_words", 32'(n), 32'(4));
      check("a_dones", 32'(dones), 32'(1));
   endtask

   task automatic b_collect(input logic [1:0] bs, input bit rnd);
      int n = 0;
      int dones = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         b_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (b_vld && b_ready) begin
            check("b_unit", 32'(b_unit), 32'(n));
            check("b_data", 32'(b_data), 32'(mk(bs, 3'(n))));
            check("b_last", 32'(b_last), 32'(n == 7));
            n++;
         end
         if (b_done) begin
            dones++;
            break;
         end
      end
      b_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (b_done) dones++;
      end
      check("b_words", 32'(n), 32'(8));
      check("b_dones", 32'(dones), 32'(1));
      check("b_busy_after", 32'(b_busy), 32'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      a_start = 0; a_chunk = 0; a_ready = 1; a_buf = 0;
      b_start = 0; b_chunk = 0; b_ready = 1; b_buf = 0;
      #3;
      check("rst_a_vld",  32'(a_vld),  32'(0));
      check("rst_a_busy", 32'(a_busy), 32'(0));
      check("rst_a_done", 32'(a_done), 32'(0));
      check("rst_a_sel",  32'(a_sel),  32'(0));
      check("rst_a_usel", 32'(a_usel), 32'(0));
      check("rst_b_vld",  32'(b_vld),  32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic drain: words on cycles 4..7 after start, done on cycle 8
      a_chunk = 1; a_ready = 1;
      a_go(2);
      check("t1_sel",  32'(a_sel),  32'(2));
      check("t1_busy", 32'(a_busy), 32'(1));
      for (int k = 2; k <= 9; k++) begin
         @(negedge clk);
         check("t1_vld",  32'(a_vld),  32'(k >= 4 && k <= 7));
         check("t1_done", 32'(a_done), 32'(k == 8));
         check("t1_busy", 32'(a_busy), 32'(k < 8));
         if (k >= 4 && k <= 7) begin
            check("t1_unit", 32'(a_unit), 32'(k - 4));
            check("t1_last", 32'(a_last), 32'(k == 7));
            check("t1_data", 32'(a_data), 32'(mk(2'd2, 3'(k - 4))));
         end
      end

      // chunk end held low, then a start pulse mid-drain that must be ignored
      a_chunk = 0;
      a_go(1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_usel", 32'(a_usel), 32'(0));
         check("t3_vld",  32'(a_vld),  32'(0));
         check("t3_busy", 32'(a_busy), 32'(1));
      end
      a_chunk = 1;
      @(negedge clk);
      check("t3_first_usel", 32'(a_usel), 32'(0));
      a_start = 1; a_buf = 3; a_chunk = 0;
      @(negedge clk);
      a_start = 0;
      check("t3_second_usel", 32'(a_usel), 32'(1));
      check("t3_vld_lat",     32'(a_vld),  32'(0));
      check("t5_sel_hold",    32'(a_sel),  32'(1));
      @(negedge clk);
      check("t3_vld_first", 32'(a_vld),  32'(1));
      check("t3_unit0",     32'(a_unit), 32'(0));
      check("t3_data0",     32'(a_data), 32'(mk(2'd1, 3'd0)));
      a_collect(2'd1, 1);
      check("t5_sel_after", 32'(a_sel), 32'(1));
      a_chunk = 1;
      a_go(3);
      check("t5_sel_new", 32'(a_sel), 32'(3));
      a_collect(2'd3, 0);

      // stalled sink: only FIFO_DEPTH reads go out, then unit_sel freezes
      b_ready = 0; b_chunk = 1;
      b_go(1);
      repeat (12) @(negedge clk);
      check("t2_usel_frozen", 32'(b_usel), 32'(3));
      check("t2_vld",         32'(b_vld),  32'(1));
      check("t2_unit_head",   32'(b_unit), 32'(0));
      repeat (3) @(negedge clk);
      check("t2_usel_still",  32'(b_usel), 32'(3));
      b_collect(2'd1, 1'b0);

      // random sink back-pressure
      b_go(2);
      b_collect(2'd2, 1'b1);

      // reset during ISSUE with two words queued
      a_ready = 0; a_chunk = 1;
      a_go(0);
      repeat (4) @(negedge clk);
      check("t6_vld_pre",  32'(a_vld),  32'(1));
      check("t6_busy_pre", 32'(a_busy), 32'(1));
      rst_n = 1'b0;
      #1;
      check("t6_vld",  32'(a_vld),  32'(0));
      check("t6_busy", 32'(a_busy), 32'(0));
      check("t6_usel", 32'(a_usel), 32'(0));
      check("t6_sel",  32'(a_sel),  32'(0));
      check("t6_data", 32'(a_data), 32'(0));
      repeat (3) begin
         @(negedge clk);
         check("t6_no_done", 32'(a_done), 32'(0));
      end
      rst_n = 1'b1;
      a_ready = 1;
      a_go(2);
      a_collect(2'd2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
